// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bundle between a word producer and seq_serializer.
// Latency: none, this is wiring only.
// Backpressure: din_ready from the serializer gates din_valid from the producer.
//
// Signals:
//   din, din_valid   producer -> serializer: parallel word and its qualifier
//   din_ready        serializer -> producer: a word can be taken this cycle
//   ser_out          serial bit stream, feeds the pattern detector's prtx input
//   ser_valid        ser_out carries a live data bit
//   word_start       first bit of a word is on ser_out
//   busy             a word is shifting or one is parked in the holding buffer
interface seq_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             word_start;
    logic             busy;

    // Serializer side.
    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output ser_out,
        output ser_valid,
        output word_start,
        output busy
    );

    // Producer / observer side.
    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  ser_out,
        input  ser_valid,
        input  word_start,
        input  busy
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in, one bit per clock out.
// Latency: first bit on ser_out right after the accepting edge; last bit WIDTH-1 cycles later.
// Backpressure: din_ready = !hb_full; at most one word shifting plus one parked in hb.
//
// Ports:
//   clk    single clock, rising edge
//   rst    asynchronous, active-high; clears everything immediately
//   bus    seq_serializer_if slave modport (din/din_valid/din_ready in,
//          ser_out/ser_valid/word_start/busy out)
//
// A one-word holding buffer lets the next word be taken while the current
// one is still shifting, so back-to-back words form an unbroken bit stream
// and a pattern straddling a word boundary reaches the detector intact.
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    seq_serializer_if.slave bus
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nx;
    logic [WIDTH-1:0] hb;
    logic [WIDTH-1:0] hb_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic             hb_full;
    logic             hb_full_nx;

    logic             accept;
    logic             last_bit;
    logic             head;
    logic             shifting;
    logic [WIDTH-1:0] sr_adv;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Ready only looks at registered state, so a producer may legally wait
    // for ready before raising valid without creating a combinational loop.
    assign bus.din_ready = ~hb_full;
    assign accept        = bus.din_valid & ~hb_full;

    // ------------------------------------------------------------------
    // Shift path
    // ------------------------------------------------------------------
    assign last_bit = (cnt == CNT_LAST);

    // Head bit leaves first; the vacated end fills with zero so an emptied
    // register reads as all-zero.
    generate
        if (MSB_FIRST) begin : g_msb
            assign head   = sr[WIDTH-1];
            assign sr_adv = {sr[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign head   = sr[0];
            assign sr_adv = {1'b0, sr[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        sr_nx      = sr;
        hb_nx      = hb;
        cnt_nx     = cnt;
        hb_full_nx = hb_full;

        case (state)
            IDLE: begin
                // Nothing in flight, so the new word skips the holding
                // buffer and starts shifting on the very next cycle.
                if (accept) begin
                    state_nx = SHIFT;
                    sr_nx    = bus.din;
                    cnt_nx   = '0;
                end
            end

            SHIFT: begin
                if (last_bit) begin
                    if (hb_full) begin
                        // Parked word takes over without a bubble. No accept
                        // can coincide here because ready is low while hb is
                        // full.
                        sr_nx      = hb;
                        hb_full_nx = 1'b0;
                        cnt_nx     = '0;
                    end else if (accept) begin
                        // Word arriving on the final-bit edge goes straight
                        // into the shift register.
                        sr_nx  = bus.din;
                        cnt_nx = '0;
                    end else begin
                        state_nx = IDLE;
                        sr_nx    = '0;
                        cnt_nx   = '0;
                    end
                end else begin
                    sr_nx  = sr_adv;
                    cnt_nx = cnt + CW'(1);
                    if (accept) begin
                        hb_nx      = bus.din;
                        hb_full_nx = 1'b1;
                    end
                end
            end

            default: begin
                state_nx   = IDLE;
                sr_nx      = '0;
                cnt_nx     = '0;
                hb_full_nx = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // Reset drops any word mid-shift and any parked word; nothing further
    // is emitted because ser_valid follows the state register directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            hb      <= '0;
            cnt     <= '0;
            hb_full <= 1'b0;
        end else begin
            state   <= state_nx;
            sr      <= sr_nx;
            hb      <= hb_nx;
            cnt     <= cnt_nx;
            hb_full <= hb_full_nx;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded from registered state)
    // ------------------------------------------------------------------
    assign shifting       = (state == SHIFT);
    assign bus.ser_valid  = shifting;
    // Forced low in IDLE so the detector sees a quiet line between bursts.
    assign bus.ser_out    = shifting & head;
    assign bus.word_start = shifting & (cnt == '0);
    assign bus.busy       = shifting | hb_full;

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the serial pattern detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `ser_out`, which drives the detector's serial input `prtx`. A one-word holding buffer lets consecutive words stream with no idle cycle between them, so patterns that span a word boundary reach the detector intact.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is 2..32.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state immediately.
- `din`  in  WIDTH  parallel word; sampled on an accepting edge.
- `din_valid`  in  1  the word on `din` is offered.
- `din_ready`  out  1  the block can take a word this cycle.
- `ser_out`  out  1  serial bit; connects to the detector's `prtx`.
- `ser_valid`  out  1  `ser_out` carries a live data bit this cycle.
- `word_start`  out  1  high during the first bit of each word.
- `busy`  out  1  high while a word is shifting or the holding buffer is full.

## Operation
- Storage:
  - shift register `sr`, WIDTH bits;
  - bit counter `cnt`, 0..WIDTH-1;
  - holding buffer `hb`, WIDTH bits, with a full flag `hb_full`.
- A word is accepted on a rising edge where `din_valid` and `din_ready` are both 1.
- `din_ready` is `!hb_full`. It is combinational from registered state and never depends on `din_valid`.
- State machine:
  - IDLE: `sr` is empty.
    - On accept, go to SHIFT. `sr` takes `din` directly, bypassing `hb`, and `cnt` is set to 0.
  - SHIFT: each edge advances `sr` by one bit and increments `cnt`.
    - If `cnt`=WIDTH-1 and `hb_full`: reload `sr` from `hb`, clear `hb_full`, set `cnt` to 0, stay in SHIFT.
    - If `cnt`=WIDTH-1, `hb` is empty and an accept occurs on the same edge: load `sr` from `din` (bypass), stay in SHIFT.
    - If `cnt`=WIDTH-1, `hb` is empty and there is no accept: go to IDLE.
    - Otherwise, if an accept occurs, write `din` into `hb` and set `hb_full`.
- Outputs:
  - `ser_out` is the current head bit of `sr`: bit WIDTH-1 when MSB_FIRST=1, bit 0 when MSB_FIRST=0.
  - `ser_out` is forced to 0 in IDLE.
  - `ser_valid` = (state==SHIFT).
  - `word_start` = (state==SHIFT && `cnt`==0).
  - `busy` = `ser_valid` | `hb_full`.
- Shifting fills vacated bit positions with 0. There is no arithmetic beyond the modulo-WIDTH counter.
- Reset mid-word: asserting `rst` aborts the word in `sr` and discards `hb` without emitting any further bits.
- A `din_valid` that is held high across reset is accepted on the first edge after `rst` deasserts.

## Timing
- Reset values:
  - state is IDLE, `sr`=0, `hb`=0, `cnt`=0, `hb_full`=0;
  - `ser_out`=0, `ser_valid`=0, `word_start`=0, `busy`=0, `din_ready`=1.
- Latency: a word accepted at edge N drives its first bit on `ser_out` from edge N through edge N+1. Its last bit is present during cycle N+WIDTH-1 to N+WIDTH.
- Throughput: sustained rate is one bit per cycle. Words accepted back-to-back produce a continuous bit stream with `ser_valid` never dropping.
- Backpressure:
  - `din_ready` drops in the cycle after `hb` fills.
  - `din_ready` returns to 1 in the cycle after `hb` is transferred into `sr`.
- Maximum occupancy is 2 words: one in `sr` and one in `hb`. A word offered while `din_ready`=0 is not taken, and `din` may change freely.
- Simultaneous events:
  - Transfer `hb`→`sr` and a new accept on the same edge is impossible, because `din_ready`=0 whenever `hb_full`=1.
  - A bypass load on the final-bit edge and an accept are the same event.

## Test plan
- Pattern feed: WIDTH=8, MSB_FIRST=1, word 8'hA8.
  - `ser_out` must be 1,0,1,0,1,0,0,0 over 8 cycles with `ser_valid`=1 throughout and `word_start` only on the first bit.
  - The downstream detector must pulse `prtz` during the 6th bit.
- Back-to-back: offer 8'hAA then 8'h55 with `din_valid` held high.
  - 16 contiguous valid bits, 1010101001010101, with no gap.
  - `word_start` at bit 0 and bit 8.
  - `din_ready` is low for exactly the cycles while `hb` holds 8'h55.
- Backpressure: hold `din_valid`=1 with three distinct words.
  - The third word is accepted only after the first finishes.
  - Output order must be word1, word2, word3, with no loss or duplication.
- Reset mid-word: assert `rst` asynchronously during bit 3 of 8'hFF while `hb` is full.
  - All outputs go to reset values immediately, with no further valid bits and `din_ready`=1.
  - After release, 8'h0F shifts out correctly.
- LSB-first: MSB_FIRST=0 with word 8'h01.
  - `ser_out` is 1,0,0,0,0,0,0,0.
  - Return to IDLE with `ser_out`=0 and `busy`=0 one cycle after the last bit.
